// File: rtl/key_entry_ctrl.sv
// Debounced keypad entry controller: collects up to four BCD digits with backspace, clear and enter.
// Optional idle-timeout discard of partial entries is built only when KEY_ENTRY_TIMEOUT_EN is defined.
module key_entry_ctrl #(
    parameter int DEB_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_key_in,
    input  logic        i_entry_ack,
    output logic        o_scan_en,
    output logic [15:0] o_digits,
    output logic [2:0]  o_digit_cnt,
    output logic        o_entry_valid,
    output logic        o_key_event,
    output logic        o_overflow,
    output logic        o_timeout
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("key_entry_ctrl: DEB_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        ACCEPT,
        WAIT_RELEASE,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_code;
    logic [4:0]        w_code_nxt;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [DEB_W-1:0]  w_deb_cnt_nxt;
    logic [15:0]       r_digits;
    logic [15:0]       w_digits_nxt;
    logic [2:0]        r_digit_cnt;
    logic [2:0]        w_digit_cnt_nxt;
    logic              w_key_event;
    logic              w_overflow;
    logic              w_timeout_hit;
    logic              w_is_digit;
    logic [3:0]        w_digit_val;

`ifdef KEY_ENTRY_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              w_idle_run;

    assign w_idle_run    = (r_state == IDLE) && (r_digit_cnt != 3'd0);
    assign w_timeout_hit = w_idle_run && (r_idle_cnt == IDLE_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idle_cnt <= '0;
        end else if (w_idle_run && !w_timeout_hit) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end else begin
            r_idle_cnt <= '0;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    // Code 10 is the zero key; 1..9 map straight onto their BCD value.
    assign w_is_digit  = (r_code >= 5'd1) && (r_code <= 5'd10);
    assign w_digit_val = (r_code == 5'd10) ? 4'd0 : r_code[3:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_deb_cnt   <= '0;
            r_digits    <= '0;
            r_digit_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_deb_cnt   <= w_deb_cnt_nxt;
            r_digits    <= w_digits_nxt;
            r_digit_cnt <= w_digit_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_deb_cnt_nxt   = r_deb_cnt;
        w_digits_nxt    = r_digits;
        w_digit_cnt_nxt = r_digit_cnt;
        w_key_event     = 1'b0;
        w_overflow      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_timeout_hit) begin
                    w_digits_nxt    = '0;
                    w_digit_cnt_nxt = '0;
                end
                if (i_key_in != 5'd0) begin
                    w_code_nxt    = i_key_in;
                    w_deb_cnt_nxt = '0;
                    w_state_nxt   = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (i_key_in != r_code) begin
                    w_deb_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_deb_cnt_nxt = '0;
                    w_state_nxt   = ACCEPT;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                end
            end

            // Acts only on the captured code, so key_in is irrelevant here.
            ACCEPT: begin
                w_key_event   = 1'b1;
                w_deb_cnt_nxt = '0;
                w_state_nxt   = WAIT_RELEASE;
                if (w_is_digit) begin
                    if (r_digit_cnt == 3'd4) begin
                        w_overflow = 1'b1;
                    end else begin
                        w_digits_nxt    = {r_digits[11:0], w_digit_val};
                        w_digit_cnt_nxt = r_digit_cnt + 3'd1;
                    end
                end else begin
                    case (r_code)
                        5'd11: begin
                            if (r_digit_cnt != 3'd0) begin
                                w_digits_nxt    = r_digits >> 4;
                                w_digit_cnt_nxt = r_digit_cnt - 3'd1;
                            end
                        end
                        5'd12: begin
                            w_digits_nxt    = '0;
                            w_digit_cnt_nxt = '0;
                        end
                        5'd13: begin
                            if (r_digit_cnt != 3'd0) begin
                                w_state_nxt = DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            WAIT_RELEASE: begin
                if (i_key_in != 5'd0) begin
                    w_deb_cnt_nxt = '0;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_deb_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                end
            end

            DONE: begin
                if (i_entry_ack) begin
                    w_digits_nxt    = '0;
                    w_digit_cnt_nxt = '0;
                    w_deb_cnt_nxt   = '0;
                    w_state_nxt     = WAIT_RELEASE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_scan_en     = (r_state != DONE);
    assign o_entry_valid = (r_state == DONE);
    assign o_digits      = r_digits;
    assign o_digit_cnt   = r_digit_cnt;
    assign o_key_event   = w_key_event;
    assign o_overflow    = w_overflow;
    assign o_timeout     = w_timeout_hit;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: table of key presses with a scoreboard of expected buffer states,
// plus hand-written sequences for bounce, DONE handling, key hold, idle timeout and asynchronous reset.
module tb_key_entry_ctrl;

    localparam int DEB     = 4;
    localparam int TIMEOUT = 100;

    logic        clk;
    logic        rst;
    logic [4:0]  keyIn;
    logic        entryAck;
    logic        scanEn;
    logic [15:0] digits;
    logic [2:0]  digitCnt;
    logic        entryValid;
    logic        keyEvent;
    logic        overflow;
    logic        timeoutPulse;

    typedef struct {
        logic [4:0]  code;
        logic [15:0] expDigits;
        logic [2:0]  expCnt;
        logic        expOvf;
        logic        expValid;
    } vec_t;

    vec_t vecs[18];
    vec_t sbQueue[$];
    vec_t pend;
    logic havePending;

    int testsRun;
    int testsFailed;
    int overflowPulses;
    int timeoutPulses;

    key_entry_ctrl #(
        .DEB_CYCLES     (DEB),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key_in      (keyIn),
        .i_entry_ack   (entryAck),
        .o_scan_en     (scanEn),
        .o_digits      (digits),
        .o_digit_cnt   (digitCnt),
        .o_entry_valid (entryValid),
        .o_key_event   (keyEvent),
        .o_overflow    (overflow),
        .o_timeout     (timeoutPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] code, input int holdCycles, input int releaseCycles);
        @(posedge clk);
        #1 keyIn = code;
        repeat (holdCycles) @(posedge clk);
        #1 keyIn = 5'd0;
        repeat (releaseCycles) @(posedge clk);
    endtask

    task automatic pushAndPress(input logic [4:0] code, input logic [15:0] expDigits, input logic [2:0] expCnt,
                                input logic expOvf, input logic expValid);
        vec_t v;
        v.code      = code;
        v.expDigits = expDigits;
        v.expCnt    = expCnt;
        v.expOvf    = expOvf;
        v.expValid  = expValid;
        sbQueue.push_back(v);
        applyStimulus(code, 8, 8);
    endtask

    // Monitor: pops one expectation per key_event and checks the buffer one cycle later.
    always @(negedge clk) begin
        if (havePending) begin
            checkOutput($sformatf("sbDigits key%0d", pend.code), digits, pend.expDigits);
            checkOutput($sformatf("sbCnt key%0d", pend.code), 16'(digitCnt), 16'(pend.expCnt));
            checkOutput($sformatf("sbValid key%0d", pend.code), 16'(entryValid), 16'(pend.expValid));
            havePending = 1'b0;
        end
        if (keyEvent) begin
            if (sbQueue.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedKeyEvent actual=1 required=0");
            end else begin
                pend = sbQueue.pop_front();
                checkOutput($sformatf("sbOverflow key%0d", pend.code), 16'(overflow), 16'(pend.expOvf));
                havePending = 1'b1;
            end
        end
        if (overflow) overflowPulses++;
        if (timeoutPulse) timeoutPulses++;
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " scanEn"}, 16'(scanEn), 16'd1);
        checkOutput({tag, " digits"}, digits, 16'h0000);
        checkOutput({tag, " digitCnt"}, 16'(digitCnt), 16'd0);
        checkOutput({tag, " entryValid"}, 16'(entryValid), 16'd0);
        checkOutput({tag, " keyEvent"}, 16'(keyEvent), 16'd0);
        checkOutput({tag, " overflow"}, 16'(overflow), 16'd0);
        checkOutput({tag, " timeout"}, 16'(timeoutPulse), 16'd0);
    endtask

    initial begin
        testsRun       = 0;
        testsFailed    = 0;
        overflowPulses = 0;
        timeoutPulses  = 0;
        havePending    = 1'b0;
        rst            = 1'b1;
        keyIn          = 5'd0;
        entryAck       = 1'b0;

        vecs[0]  = '{5'd3,  16'h0003, 3'd1, 1'b0, 1'b0};
        vecs[1]  = '{5'd11, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{5'd11, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{5'd13, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[4]  = '{5'd1,  16'h0001, 3'd1, 1'b0, 1'b0};
        vecs[5]  = '{5'd2,  16'h0012, 3'd2, 1'b0, 1'b0};
        vecs[6]  = '{5'd3,  16'h0123, 3'd3, 1'b0, 1'b0};
        vecs[7]  = '{5'd4,  16'h1234, 3'd4, 1'b0, 1'b0};
        vecs[8]  = '{5'd5,  16'h1234, 3'd4, 1'b1, 1'b0};
        vecs[9]  = '{5'd14, 16'h1234, 3'd4, 1'b0, 1'b0};
        vecs[10] = '{5'd11, 16'h0123, 3'd3, 1'b0, 1'b0};
        vecs[11] = '{5'd12, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[12] = '{5'd7,  16'h0007, 3'd1, 1'b0, 1'b0};
        vecs[13] = '{5'd8,  16'h0078, 3'd2, 1'b0, 1'b0};
        vecs[14] = '{5'd11, 16'h0007, 3'd1, 1'b0, 1'b0};
        vecs[15] = '{5'd1,  16'h0071, 3'd2, 1'b0, 1'b0};
        vecs[16] = '{5'd10, 16'h0710, 3'd3, 1'b0, 1'b0};
        vecs[17] = '{5'd13, 16'h0710, 3'd3, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // A two-cycle bounce must not register.
        applyStimulus(5'd5, 2, 8);
        @(negedge clk);
        checkOutput("bounceDigits", digits, 16'h0000);
        checkOutput("bounceCnt", 16'(digitCnt), 16'd0);

        for (int i = 0; i < 18; i++) begin
            sbQueue.push_back(vecs[i]);
            applyStimulus(vecs[i].code, 8, 8);
        end

        // Held in DONE: scanner disabled, keys ignored, buffer frozen.
        @(negedge clk);
        checkOutput("doneScanEn", 16'(scanEn), 16'd0);
        checkOutput("doneValid", 16'(entryValid), 16'd1);
        applyStimulus(5'd5, 10, 2);
        @(negedge clk);
        checkOutput("doneFrozenDigits", digits, 16'h0710);
        checkOutput("doneFrozenCnt", 16'(digitCnt), 16'd3);
        @(posedge clk);
        #1 entryAck = 1'b1;
        @(posedge clk);
        #1 entryAck = 1'b0;
        @(negedge clk);
        checkOutput("ackValid", 16'(entryValid), 16'd0);
        checkOutput("ackDigits", digits, 16'h0000);
        checkOutput("ackCnt", 16'(digitCnt), 16'd0);
        checkOutput("ackScanEn", 16'(scanEn), 16'd1);
        repeat (8) @(posedge clk);

        // Ack outside DONE is ignored.
        pushAndPress(5'd7,  16'h0007, 3'd1, 1'b0, 1'b0);
        pushAndPress(5'd8,  16'h0078, 3'd2, 1'b0, 1'b0);
        pushAndPress(5'd11, 16'h0007, 3'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1 entryAck = 1'b1;
        @(posedge clk);
        #1 entryAck = 1'b0;
        @(negedge clk);
        checkOutput("strayAckDigits", digits, 16'h0007);
        checkOutput("strayAckCnt", 16'(digitCnt), 16'd1);

        // A long hold produces exactly one key event.
        sbQueue.push_back('{5'd9, 16'h0079, 3'd2, 1'b0, 1'b0});
        applyStimulus(5'd9, 40, 8);

        pushAndPress(5'd12, 16'h0000, 3'd0, 1'b0, 1'b0);
        pushAndPress(5'd6,  16'h0006, 3'd1, 1'b0, 1'b0);
        repeat (150) @(posedge clk);
        @(negedge clk);
`ifdef KEY_ENTRY_TIMEOUT_EN
        checkOutput("timeoutPulses", 16'(timeoutPulses), 16'd1);
        checkOutput("timeoutCnt", 16'(digitCnt), 16'd0);
        checkOutput("timeoutDigits", digits, 16'h0000);
`else
        checkOutput("timeoutPulses", 16'(timeoutPulses), 16'd0);
        checkOutput("persistCnt", 16'(digitCnt), 16'd1);
        checkOutput("persistDigits", digits, 16'h0006);
`endif

        // Reset mid-debounce discards the pending key without a pulse.
        @(posedge clk);
        #1 keyIn = 5'd4;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1 checkResetValues("rstDebounce");
        repeat (3) @(posedge clk);
        #1 keyIn = 5'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkResetValues("afterRstDebounce");

        // Reset while in DONE drops the entry.
        pushAndPress(5'd2,  16'h0002, 3'd1, 1'b0, 1'b0);
        pushAndPress(5'd13, 16'h0002, 3'd1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("preRstDoneValid", 16'(entryValid), 16'd1);
        #2 rst = 1'b1;
        #1 checkResetValues("rstDone");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        checkOutput("sbDrained", 16'(sbQueue.size()), 16'd0);
        checkOutput("overflowPulses", 16'(overflowPulses), 16'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/key_entry_ctrl.md
KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000: consecutive clk cycles a key code, or the all-released state, must be stable before it is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000: idle cycles before a partial entry is discarded (used only with KEY_ENTRY_TIMEOUT_EN).
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 key_in  input  5  scanner key code: 0 = none, 1..16 = key.
REQ-006 entry_ack  input  1  consumer acknowledge of a completed entry.
REQ-007 scan_en  output  1  scanner enable; low holds the scanner in its reset state.
REQ-008 digits  output  16  four BCD digits; newest digit in [3:0].
REQ-009 digit_cnt  output  3  number of valid digits, 0..4.
REQ-010 entry_valid  output  1  completed entry is held on digits/digit_cnt.
REQ-011 key_event  output  1  one-cycle pulse per accepted key.
REQ-012 overflow  output  1  one-cycle pulse when a digit is rejected because the buffer is full.
REQ-013 timeout  output  1  one-cycle pulse when a partial entry is discarded.

Function
REQ-014 Key map: codes 1..9 are digits 1..9; code 10 is digit 0; 11 is backspace; 12 is clear; 13 is enter; 14..16 are accepted (key_event pulses) with no other effect.
REQ-015 FSM states SHALL be IDLE, DEBOUNCE, ACCEPT, WAIT_RELEASE and DONE.
REQ-016 IDLE: when key_in != 0, capture the code, clear the debounce counter and go to DEBOUNCE.
REQ-017 DEBOUNCE: when key_in != captured code, go to IDLE; after DEB_CYCLES consecutive matching cycles, go to ACCEPT.
REQ-018 ACCEPT lasts exactly one cycle and pulses key_event; the buffer update is visible on the next cycle.
REQ-019 Digit with digit_cnt < 4: digits <= {digits[11:0], d} and digit_cnt+1.
REQ-020 Digit with digit_cnt == 4: buffer unchanged; overflow pulses in the ACCEPT cycle.
REQ-021 Backspace: digits <= digits >> 4 and digit_cnt-1; no-op when digit_cnt == 0.
REQ-022 Clear: digits <= 0 and digit_cnt <= 0.
REQ-023 Enter with digit_cnt > 0: ACCEPT -> DONE. Enter with digit_cnt == 0 is ignored.
REQ-024 All other ACCEPT outcomes go to WAIT_RELEASE.
REQ-025 WAIT_RELEASE: after DEB_CYCLES consecutive cycles of key_in == 0, go to IDLE; any nonzero cycle restarts the count. Holding a key never repeats it.
REQ-026 DONE: entry_valid = 1, scan_en = 0, and digits/digit_cnt are frozen.
REQ-027 DONE: entry_ack clears digits and digit_cnt and goes to WAIT_RELEASE in the same edge; entry_valid falls the next cycle.
REQ-028 entry_ack outside DONE SHALL be ignored.
REQ-029 scan_en SHALL be 1 in every state except DONE.
REQ-030 A key_in change during ACCEPT has no effect on that cycle's action.

Reset
REQ-031 rst SHALL asynchronously force the following and hold them while high: state IDLE, digits 0, digit_cnt 0, entry_valid 0, key_event 0, overflow 0, timeout 0, scan_en 1, all counters 0.
REQ-032 rst asserted mid-debounce or in DONE SHALL discard the pending key or entry without any pulse.

Configuration
REQ-033 With KEY_ENTRY_TIMEOUT_EN defined: an idle counter runs in IDLE while digit_cnt > 0 and clears on any other state.
REQ-034 With KEY_ENTRY_TIMEOUT_EN defined: when the idle counter reaches TIMEOUT_CYCLES, the block clears digits and digit_cnt and pulses timeout for one cycle.
REQ-035 Without KEY_ENTRY_TIMEOUT_EN: no idle counter is built, timeout is tied 0, and partial entries persist indefinitely.

Verification (DEB_CYCLES=4, TIMEOUT_CYCLES=100)
REQ-036 key_in=3 for 6 cycles, then 0 for 6 -> one key_event; digits=0x0003, digit_cnt=1.
REQ-037 key_in=5 for 2 cycles, then 0 (bounce) -> no key_event; buffer unchanged.
REQ-038 Keys 1,2,3,4,5, each cleanly released -> digits=0x1234, digit_cnt=4; overflow pulses once, on key 5.
REQ-039 Keys 1,10, then 13 -> entry_valid=1, scan_en=0, digits=0x0010; entry_ack one cycle -> digits=0, digit_cnt=0, entry_valid=0 next cycle.
REQ-040 Keys 7,8, then 11 -> digits=0x0007, digit_cnt=1; hold key_in=9 for 40 cycles -> exactly one key_event.
REQ-041 KEY_ENTRY_TIMEOUT_EN, key 6, then idle for 100 cycles -> timeout pulse; digit_cnt=0. rst pulse mid-DEBOUNCE -> all outputs at reset values.
